// File: rtl/button_event_queue.sv
// Per-frame button debounce, press/auto-repeat event generation and a small FWFT command queue.
// Define AUTOREPEAT_EN to build the held-direction auto-repeat counter; omit it for press-only events.
module button_event_queue #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 6,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        vga_vs,
  input  logic [11:0] botoes,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [3:0]  cmd,
  output logic [11:0] held,
  output logic        overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 7 || REPEAT_RATE == 0 ||
      REPEAT_RATE > REPEAT_DELAY || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("button_event_queue: illegal parameter set");
  end

  // Bit position of each command code; priority follows code order (lowest code first).
  function automatic logic [3:0] code_bit(input int unsigned c);
    case (c)
      1:       code_bit = 4'd11;
      2:       code_bit = 4'd10;
      3:       code_bit = 4'd9;
      4:       code_bit = 4'd8;
      5:       code_bit = 4'd7;
      6:       code_bit = 4'd6;
      7:       code_bit = 4'd5;
      8:       code_bit = 4'd1;
      9:       code_bit = 4'd0;
      10:      code_bit = 4'd4;
      11:      code_bit = 4'd3;
      default: code_bit = 4'd2;
    endcase
  endfunction

  // Frame tick from vga_vs falling edge
  logic vs_meta_q, vs_sync_q, vs_prev_q;
  logic frame_tick;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_meta_q <= vga_vs;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign frame_tick = vs_prev_q & ~vs_sync_q;

  // Debounce
  logic [11:0]      held_q, held_d;
  logic [11:0][2:0] db_cnt_q, db_cnt_d;
  logic [11:0]      press;

  always_comb begin
    held_d   = held_q;
    db_cnt_d = db_cnt_q;
    if (frame_tick) begin
      for (int i = 0; i < 12; i++) begin
        if (botoes[i] != held_q[i]) begin
          if (({1'b0, db_cnt_q[i]} + 4'd1) == 4'(DEBOUNCE_FRAMES)) begin
            held_d[i]   = ~held_q[i];
            db_cnt_d[i] = 3'd0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 3'd1;
          end
        end else begin
          db_cnt_d[i] = 3'd0;
        end
      end
    end
  end

  assign press = held_d & ~held_q;

  // Auto-repeat of the highest-priority held direction
  logic [11:0] repeat_set;

`ifdef AUTOREPEAT_EN
  localparam int unsigned      RptW      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RptW:0]    RptDelay  = (RptW + 1)'(REPEAT_DELAY);
  localparam logic [RptW-1:0]  RptReload = RptW'(REPEAT_DELAY - REPEAT_RATE);

  function automatic logic [3:0] dir_code(input logic [11:0] h);
    if (h[11])      dir_code = 4'd1;
    else if (h[10]) dir_code = 4'd2;
    else if (h[9])  dir_code = 4'd3;
    else if (h[8])  dir_code = 4'd4;
    else            dir_code = 4'd0;
  endfunction

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [3:0]      dir_old, dir_new;

  always_comb begin
    dir_old    = dir_code(held_q);
    dir_new    = dir_code(held_d);
    rpt_cnt_d  = rpt_cnt_q;
    repeat_set = '0;
    if (frame_tick) begin
      if (dir_new == 4'd0 || dir_new != dir_old) begin
        rpt_cnt_d = '0;
      end else if (({1'b0, rpt_cnt_q} + 1'b1) == RptDelay) begin
        // Direction codes 1..4 map onto bits 11..8
        repeat_set = 12'h800 >> (dir_new - 4'd1);
        rpt_cnt_d  = RptReload;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) rpt_cnt_q <= '0;
    else       rpt_cnt_q <= rpt_cnt_d;
  end
`else
  assign repeat_set = '0;
`endif

  // Pending events, drained one per non-tick cycle
  logic [11:0] pending_q, pending_d, drain_mask;
  logic        push;
  logic [3:0]  push_code;

  always_comb begin
    push       = 1'b0;
    push_code  = 4'd0;
    drain_mask = '0;
    if (!frame_tick) begin
      for (int c = 12; c >= 1; c--) begin
        if (pending_q[code_bit(c)]) begin
          push       = 1'b1;
          push_code  = 4'(c);
          drain_mask = 12'd1 << code_bit(c);
        end
      end
    end
    pending_d = (pending_q & ~drain_mask) | press | repeat_set;
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      held_q    <= '0;
      db_cnt_q  <= '0;
      pending_q <= '0;
    end else begin
      held_q    <= held_d;
      db_cnt_q  <= db_cnt_d;
      pending_q <= pending_d;
    end
  end

  // First-word fall-through command queue
  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [3:0]      last_q;
  logic            overflow_q;
  logic            full, pop, do_push, drop;

  assign full    = count_q == CntW'(FIFO_DEPTH);
  assign pop     = cmd_valid & cmd_ready;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clock_50) begin
    if (do_push) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign cmd_valid = count_q != '0;
  assign cmd       = cmd_valid ? mem_q[rd_ptr_q] : last_q;
  assign held      = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: debounce, press latency, queue fill/overflow,
// reset flush and (with AUTOREPEAT_EN) direction auto-repeat timing.
module tb_button_event_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_vs;
  logic [11:0] botoes;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [3:0]  cmd;
  logic [11:0] held;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;
  int start_f;
  int beat_cmd[$];
  int beat_frame[$];

  always #10 clk = ~clk;

  button_event_queue dut (
    .clock_50  (clk),
    .reset     (reset),
    .vga_vs    (vga_vs),
    .botoes    (botoes),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .held      (held),
    .overflow  (overflow)
  );

  // Record every accepted beat with the frame it occurred in
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      beat_cmd.push_back(int'(cmd));
      beat_frame.push_back(frame_no);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Falling vga_vs; returns just after the edge that applies the frame_tick update
  task automatic fall();
    frame_no++;
    vga_vs = 1'b0;
    cyc(3);
  endtask

  task automatic rise();
    vga_vs = 1'b1;
    cyc(9);
  endtask

  task automatic frame();
    fall();
    rise();
  endtask

  task automatic clear_beats();
    beat_cmd.delete();
    beat_frame.delete();
  endtask

  initial begin
    reset     = 1'b1;
    vga_vs    = 1'b1;
    botoes    = 12'h000;
    cmd_ready = 1'b0;
    cyc(3);
    reset = 1'b0;
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_held", held, 0);
    check("rst_overflow", overflow, 0);

    // Idle frames
    cmd_ready = 1'b1;
    repeat (5) frame();
    check("idle_valid", cmd_valid, 0);
    check("idle_held", held, 0);
    check("idle_overflow", overflow, 0);
    check("idle_beats", beat_cmd.size(), 0);

    // Single press of A: held at 2nd tick, beat 2 cycles after that tick
    clear_beats();
    botoes = 12'h080;
    fall();
    check("a_held_tick1", held, 12'h000);
    rise();
    fall();
    check("a_held_tick2", held, 12'h080);
    check("a_valid_at_tick", cmd_valid, 0);
    cyc(1);
    check("a_valid_lat2", cmd_valid, 1);
    check("a_cmd", cmd, 5);
    cyc(1);
    check("a_valid_drop", cmd_valid, 0);
    rise();
    frame();
    frame();
    check("a_beat_count", beat_cmd.size(), 1);
    if (beat_cmd.size() >= 1) check("a_beat_code", beat_cmd[0], 5);

    // Release, then a one-frame glitch
    botoes = 12'h000;
    repeat (3) frame();
    check("rel_held", held, 0);
    clear_beats();
    botoes = 12'h080;
    frame();
    botoes = 12'h000;
    repeat (3) frame();
    check("glitch_held", held, 0);
    check("glitch_beats", beat_cmd.size(), 0);

    // Fill queue with Up, A, B, Start while stalled, then overflow with Mode
    cmd_ready = 1'b0;
    botoes    = 12'h8C2;
    frame();
    frame();
    check("fill_held", held, 12'h8C2);
    check("fill_valid", cmd_valid, 1);
    check("fill_head", cmd, 1);
    check("fill_overflow", overflow, 0);
    botoes = 12'h8C3;
    frame();
    frame();
    check("ovf_held", held, 12'h8C3);
    check("ovf_overflow", overflow, 1);
    check("ovf_head", cmd, 1);
    clear_beats();
    cmd_ready = 1'b1;
    cyc(8);
    check("drain_count", beat_cmd.size(), 4);
    if (beat_cmd.size() == 4) begin
      check("drain_0", beat_cmd[0], 1);
      check("drain_1", beat_cmd[1], 5);
      check("drain_2", beat_cmd[2], 6);
      check("drain_3", beat_cmd[3], 8);
    end
    check("drain_valid", cmd_valid, 0);
    check("drain_cmd_hold", cmd, 8);
    check("drain_overflow_sticky", overflow, 1);

    // Reset with three entries queued
    botoes = 12'h000;
    repeat (3) frame();
    cmd_ready = 1'b0;
    botoes    = 12'h0E0;
    frame();
    frame();
    check("pre_rst_valid", cmd_valid, 1);
    check("pre_rst_head", cmd, 5);
    clear_beats();
    botoes = 12'h000;
    reset  = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_held", held, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_cmd", cmd, 0);
    cmd_ready = 1'b1;
    repeat (3) frame();
    check("post_rst_beats", beat_cmd.size(), 0);

    // Hold Right for 40 frames
    clear_beats();
    botoes  = 12'h100;
    start_f = frame_no;
    repeat (40) frame();
`ifdef AUTOREPEAT_EN
    check("rpt_right_count", beat_cmd.size(), 5);
    for (int k = 0; k < beat_cmd.size() && k < 5; k++) begin
      check("rpt_right_code", beat_cmd[k], 4);
      check("rpt_right_frame", beat_frame[k] - start_f, (k == 0) ? 2 : 16 + 6 * k);
    end
`else
    check("norpt_right_count", beat_cmd.size(), 1);
    if (beat_cmd.size() >= 1) begin
      check("norpt_right_code", beat_cmd[0], 4);
      check("norpt_right_frame", beat_frame[0] - start_f, 2);
    end
`endif

    // Add Up while Right stays held
    clear_beats();
    botoes  = 12'h900;
    start_f = frame_no;
    repeat (22) frame();
`ifdef AUTOREPEAT_EN
    check("rpt_up_count", beat_cmd.size(), 2);
    for (int k = 0; k < beat_cmd.size() && k < 2; k++) begin
      check("rpt_up_code", beat_cmd[k], 1);
      check("rpt_up_frame", beat_frame[k] - start_f, (k == 0) ? 2 : 22);
    end
`else
    check("norpt_up_count", beat_cmd.size(), 1);
    if (beat_cmd.size() >= 1) begin
      check("norpt_up_code", beat_cmd[0], 1);
      check("norpt_up_frame", beat_frame[0] - start_f, 2);
    end
`endif
    check("final_held", held, 12'h900);
    check("final_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
